// File: rtl/npu_seq_pkg.sv
// Shared encodings for the NPU global sequencer: FSM states, job modes and drain length.
package npu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        EXEC,
        DRAIN,
        DONE_S
    } seq_state_t;

    localparam logic [1:0] MODE_WLOAD = 2'd0;
    localparam logic [1:0] MODE_EXEC  = 2'd1;

    localparam int NPU_N     = 4;
    localparam int DRAIN_CYC = 2 * NPU_N - 1;

endpackage

// File: rtl/npu_seq_if.sv
// Bundle between the control block, the upstream row stream and the systolic array inputs.
interface npu_seq_if #(
    parameter int ARRAY_N = 4,
    parameter int CNT_W   = 32
);
    logic                   seq_start;
    logic [1:0]             seq_mode;
    logic [CNT_W-1:0]       seq_total_rows;
    logic                   seq_busy;
    logic                   seq_done;
    logic                   in_valid;
    logic                   in_ready;
    logic [8*ARRAY_N-1:0]   in_data;
    logic                   arr_load_weight;
    logic [ARRAY_N-1:0]     arr_valid_in;
    logic [8*ARRAY_N-1:0]   arr_x_in;

    modport master (
        output seq_start, seq_mode, seq_total_rows, in_valid, in_data,
        input  seq_busy, seq_done, in_ready, arr_load_weight, arr_valid_in, arr_x_in
    );

    modport slave (
        input  seq_start, seq_mode, seq_total_rows, in_valid, in_data,
        output seq_busy, seq_done, in_ready, arr_load_weight, arr_valid_in, arr_x_in
    );
endinterface

// File: rtl/npu_seq_skew_buf.sv
// Triangular skew bank: lane i delays its byte and valid by i+1 cycles; weight rows bypass it.
module npu_skew_buf #(
    parameter int ARRAY_N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_beat,
    input  logic                 i_bypass,
    input  logic [8*ARRAY_N-1:0] i_data,
    output logic                 o_load,
    output logic [ARRAY_N-1:0]   o_valid,
    output logic [8*ARRAY_N-1:0] o_data
);
    logic                 r_load;
    logic [8*ARRAY_N-1:0] r_wdata;
    logic                 w_wbeat;
    logic                 w_xbeat;

    assign w_wbeat = i_beat & i_bypass;
    assign w_xbeat = i_beat & ~i_bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load  <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_load  <= w_wbeat;
            r_wdata <= w_wbeat ? i_data : '0;
        end
    end

    assign o_load = r_load;

    for (genvar gi = 0; gi < ARRAY_N; gi++) begin : g_lane
        logic [gi:0]       r_v;
        logic signed [7:0] r_d [gi+1];

        // Bypass doubles as a flush so a weight load never sees stale activations.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= '0;
                for (int k = 0; k <= gi; k++) r_d[k] <= '0;
            end else begin
                r_v[0] <= w_xbeat;
                r_d[0] <= w_xbeat ? $signed(i_data[8*gi +: 8]) : '0;
                for (int k = 1; k <= gi; k++) begin
                    r_v[k] <= i_bypass ? 1'b0 : r_v[k-1];
                    r_d[k] <= i_bypass ? '0   : r_d[k-1];
                end
            end
        end

        assign o_valid[gi]       = r_load | r_v[gi];
        assign o_data[8*gi +: 8] = r_load ? r_wdata[8*gi +: 8] : r_d[gi];
    end
endmodule

// File: rtl/npu_seq.sv
// NPU global sequencer: job FSM, row countdown and handoff of accepted rows to the skew bank.
module npu_seq
    import npu_pkg::*;
#(
    parameter int ARRAY_N = 4,
    parameter int CNT_W   = 32
) (
    input logic      clk,
    input logic      rst_n,
    npu_seq_if.slave bus
);
    // DRAIN_CYC is quoted for the default array; rescale it for other lane counts.
    localparam int DRAIN_N = DRAIN_CYC + 2 * (ARRAY_N - NPU_N);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_ready;
    logic             w_beat;
    logic             w_last;
    logic             w_start_ok;

    assign w_ready    = ((r_state == WLOAD) || (r_state == EXEC)) && (r_cnt != '0);
    assign w_beat     = bus.in_valid & w_ready;
    assign w_last     = (r_cnt == '0) || (w_beat && (r_cnt == CNT_W'(1)));
    assign w_start_ok = (r_state == IDLE) && bus.seq_start &&
                        ((bus.seq_mode == MODE_WLOAD) || (bus.seq_mode == MODE_EXEC));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    if (bus.seq_mode == MODE_WLOAD) begin
                        w_state_nxt = WLOAD;
                        w_cnt_nxt   = CNT_W'(ARRAY_N);
                    end else begin
                        w_state_nxt = EXEC;
                        w_cnt_nxt   = bus.seq_total_rows;
                    end
                end
            end
            WLOAD, EXEC: begin
                if (w_beat) w_cnt_nxt = r_cnt - CNT_W'(1);
                // The last beat leaves immediately; a zero-row job leaves on its first cycle.
                if (w_last) begin
                    w_state_nxt = (r_state == WLOAD) ? DONE_S : DRAIN;
                    w_cnt_nxt   = CNT_W'(DRAIN_N - 1);
                end
            end
            DRAIN: begin
                if (r_cnt == '0) w_state_nxt = DONE_S;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            DONE_S:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_start_ok)                 r_done <= 1'b0;
            else if (w_state_nxt == DONE_S) r_done <= 1'b1;
        end
    end

    assign bus.seq_busy = r_busy;
    assign bus.seq_done = r_done;
    assign bus.in_ready = w_ready;

    npu_skew_buf #(.ARRAY_N(ARRAY_N)) u_skew (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_beat   (w_beat),
        .i_bypass (r_state == WLOAD),
        .i_data   (bus.in_data),
        .o_load   (bus.arr_load_weight),
        .o_valid  (bus.arr_valid_in),
        .o_data   (bus.arr_x_in)
    );
endmodule

// File: tb/tb_npu_seq.sv
// Scoreboard bench for npu_seq: stimulus pushes expected array feeds, a negedge monitor pops and compares.
module tb_npu_seq;
    localparam int N  = 4;
    localparam int CW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    npu_seq_if #(.ARRAY_N(N), .CNT_W(CW)) bus ();
    npu_seq #(.ARRAY_N(N), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { int cyc; int lane; logic [7:0] d; } exp_t;
    typedef struct { int cyc; logic [8*N-1:0] d; } wexp_t;

    exp_t  lq[$];
    wexp_t wq[$];
    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] wrow [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endfunction

    // Monitor: each presented weight row / lane byte must match the oldest expectation, on its cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.arr_load_weight) begin
                chk("w_valid_all", bus.arr_valid_in, {N{1'b1}});
                if (wq.size() == 0) chk("w_unexpected_load", bus.arr_load_weight, 0);
                else begin
                    chk("w_cycle", cyc, wq[0].cyc);
                    chk("w_data", bus.arr_x_in, wq[0].d);
                    void'(wq.pop_front());
                end
            end else begin
                if (wq.size() != 0 && wq[0].cyc <= cyc) begin
                    chk("w_missing_load", bus.arr_load_weight, 1);
                    void'(wq.pop_front());
                end
                for (int i = 0; i < N; i++) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < lq.size(); j++)
                        if (idx < 0 && lq[j].lane == i) idx = j;
                    if (bus.arr_valid_in[i]) begin
                        if (idx < 0) chk($sformatf("lane%0d_unexpected_valid", i), bus.arr_valid_in[i], 0);
                        else begin
                            chk($sformatf("lane%0d_cycle", i), cyc, lq[idx].cyc);
                            chk($sformatf("lane%0d_data", i), bus.arr_x_in[8*i +: 8], lq[idx].d);
                            lq.delete(idx);
                        end
                    end else begin
                        chk($sformatf("lane%0d_zero_when_idle", i), bus.arr_x_in[8*i +: 8], 0);
                        if (idx >= 0 && lq[idx].cyc <= cyc) begin
                            chk($sformatf("lane%0d_missing_valid", i), bus.arr_valid_in[i], 1);
                            lq.delete(idx);
                        end
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, bus.seq_busy, 0);
        chk({tag, "_done"}, bus.seq_done, 0);
        chk({tag, "_ready"}, bus.in_ready, 0);
        chk({tag, "_valid"}, bus.arr_valid_in, 0);
        chk({tag, "_load"}, bus.arr_load_weight, 0);
        chk({tag, "_x"}, bus.arr_x_in, 0);
    endtask

    task automatic start(input logic [1:0] m, input logic [31:0] rows);
        bus.seq_start      = 1'b1;
        bus.seq_mode       = m;
        bus.seq_total_rows = rows;
        @(posedge clk); #1;
        bus.seq_start      = 1'b0;
        bus.seq_mode       = 2'($urandom);
        bus.seq_total_rows = $urandom;
    endtask

    // n = cycles from the first post-stimulus cycle until the DONE_S cycle (inclusive).
    task automatic finish_job(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("tail_ready_off", bus.in_ready, 0);
            chk("tail_busy", bus.seq_busy, 1);
            chk("tail_done", bus.seq_done, (k == n));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("idle_busy_low", bus.seq_busy, 0);
        chk("idle_done_held", bus.seq_done, 1);
        @(posedge clk); #1;
    endtask

    task automatic reset_check();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        lq.delete();
        wq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wload_job(input bit rnd);
        int got;
        logic [8*N-1:0] row;
        start(2'd0, $urandom);
        got = 0;
        for (int it = 0; got < N && it < 200; it++) begin
            row = rnd ? (8*N)'($urandom) : wrow[got];
            bus.in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = row;
            @(negedge clk);
            chk("wl_ready", bus.in_ready, 1);
            chk("wl_busy", bus.seq_busy, 1);
            chk("wl_done_clr", bus.seq_done, 0);
            if (bus.in_valid) begin
                wq.push_back('{cyc + 1, row});
                got++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        finish_job(1);
    endtask

    task automatic exec_job(input logic [31:0] rows, input logic [15:0] pat, input int pat_len,
                            input int stray_at, input int abort_after);
        int rem;
        int beats;
        logic v;
        logic [31:0] row;
        start(2'd1, rows);
        rem   = rows;
        beats = 0;
        for (int it = 0; rem > 0 && it < 400; it++) begin
            v   = (pat_len > 0) ? pat[it % pat_len] : ($urandom_range(0, 3) != 0);
            row = $urandom;
            bus.in_valid = v;
            bus.in_data  = row;
            if (it == stray_at) begin
                bus.seq_start      = 1'b1;
                bus.seq_mode       = 2'd0;
                bus.seq_total_rows = 32'd1;
            end
            @(negedge clk);
            chk("ex_ready", bus.in_ready, 1);
            chk("ex_busy", bus.seq_busy, 1);
            chk("ex_done_clr", bus.seq_done, 0);
            if (v) begin
                for (int i = 0; i < N; i++) lq.push_back('{cyc + 1 + i, i, row[8*i +: 8]});
                rem--;
                beats++;
            end
            @(posedge clk); #1;
            bus.seq_start = 1'b0;
            if (abort_after > 0 && beats == abort_after) begin
                reset_check();
                return;
            end
        end
        bus.in_valid = 1'b0;
        finish_job((rows == 0) ? 2*N + 1 : 2*N);
    endtask

    task automatic ignored_reserved_mode();
        bus.seq_start      = 1'b1;
        bus.seq_mode       = 2'd3;
        bus.seq_total_rows = 32'd5;
        @(posedge clk); #1;
        bus.seq_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rsv_busy", bus.seq_busy, 0);
            chk("rsv_done_kept", bus.seq_done, 1);
            chk("rsv_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.seq_start      = 1'b0;
        bus.seq_mode       = 2'd0;
        bus.seq_total_rows = '0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        rst_n              = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        wload_job(1'b0);
        exec_job(32'd3, 16'h0001, 1, -1, 0);
        exec_job(32'd5, 16'h00AD, 8, -1, 0);
        exec_job(32'd0, 16'h0000, 0, -1, 0);
        exec_job(32'd7, 16'h0000, 0, 2, 0);
        ignored_reserved_mode();
        exec_job(32'd6, 16'h0001, 1, -1, 2);
        wload_job(1'b0);
        wload_job(1'b1);
        exec_job(32'd20, 16'h0000, 0, -1, 0);

        repeat (2*N) @(negedge clk);
        chk("lane_queue_drained", lq.size(), 0);
        chk("w_queue_drained", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/npu_seq.md
Name: npu_seq

Overview:
- Global sequencer directly downstream of the NPU register/control block.
- Consumes the single-cycle seq_start pulse, seq_mode and seq_total_rows; returns seq_busy and seq_done.
- Pulls 8-bit-per-lane row vectors from an upstream valid/ready stream and feeds them into an N-lane systolic array.
- Weight rows go in unskewed with load_weight asserted. Activation rows go in diagonally skewed, followed by a pipeline drain.

Parameters:
- ARRAY_N, 4, number of array lanes (rows/columns of the square array); legal range 2..16.
- CNT_W, 32, width of the row counter; matches seq_total_rows.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seq_start  input  1  one-cycle start pulse from the control block.
- seq_mode  input  2  0 = weight load, 1 = execution, 2/3 = reserved.
- seq_total_rows  input  CNT_W  activation row count for execution mode.
- seq_busy  output  1  high while a job is in progress.
- seq_done  output  1  sticky completion flag.
- in_valid  input  1  upstream row valid.
- in_ready  output  1  sequencer accepts a row this cycle.
- in_data  input  8*ARRAY_N  row vector; lane i = bits [8i+7:8i], signed.
- arr_load_weight  output  1  array latches the weights on arr_x_in.
- arr_valid_in  output  ARRAY_N  per-lane data valid.
- arr_x_in  output  8*ARRAY_N  per-lane data into the array.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; skew registers 0.
- States and transitions:
  - IDLE -> WLOAD on seq_start with mode 0.
  - IDLE -> EXEC on seq_start with mode 1.
  - WLOAD -> DONE_S after ARRAY_N accepted beats.
  - EXEC -> DRAIN after seq_total_rows accepted beats.
  - DRAIN -> DONE_S after 2*ARRAY_N-1 cycles.
  - DONE_S -> IDLE unconditionally, one cycle later.
- Start handling:
  - seq_start is sampled only in IDLE.
  - On start, seq_mode and seq_total_rows are latched; later changes to the inputs have no effect.
  - seq_start while not in IDLE is ignored.
  - seq_start with mode 2 or 3 is ignored: no state change, seq_done unchanged.
- seq_busy: registered, 1 from the cycle after the accepted start through the DONE_S cycle; 0 in IDLE.
- seq_done:
  - Set to 1 in the cycle DONE_S is entered.
  - Holds until the next accepted seq_start, which clears it in the same edge busy rises.
  - Remains 0 after reset until the first job completes.
- in_ready: combinational = (state==WLOAD or EXEC) and rows_remaining != 0. A beat is accepted when in_valid & in_ready.
- WLOAD beat: the same cycle's data is registered to arr_x_in with arr_valid_in = all ones and arr_load_weight = 1, one cycle after acceptance. The skew path is bypassed.
- EXEC beat:
  - Lane i output = lane i of the accepted row delayed i+1 cycles.
  - arr_valid_in[i] follows the accepted-beat strobe delayed i+1 cycles.
  - Lane 0 therefore appears 1 cycle after acceptance; lane ARRAY_N-1 appears ARRAY_N cycles after.
  - arr_load_weight = 0.
  - Bubbles (in_valid low) propagate as per-lane valid=0; arr_x_in is 0 when the lane valid is 0.
- DRAIN: no beats accepted. The skew shift continues until every lane is flushed; the remaining cycles cover array propagation.
- seq_total_rows == 0 in execution mode: EXEC -> DRAIN on the next cycle, zero beats accepted, normal drain, then done.
- The row counter counts down from the latched value, with no wrap: 0xFFFFFFFF rows is legal.
- Reset mid-job: all state is discarded immediately; busy, done, valids and ready go to 0. No partial done is signalled.

Decomposition:
- Shared package npu_pkg holds:
  - the state encoding (IDLE, WLOAD, EXEC, DRAIN, DONE_S);
  - the mode constants (MODE_WLOAD = 2'd0, MODE_EXEC = 2'd1);
  - the localparam DRAIN_CYC = 2*ARRAY_N-1.
- One sub-module, npu_skew_buf:
  - parameterised by ARRAY_N;
  - a triangular register bank giving lane i a delay of i+1, carrying data plus valid;
  - includes a bypass/flush input for WLOAD.

Test Plan:
- Weight load, ARRAY_N=4: start mode 0, 4 back-to-back rows 0x04030201..0x10 0F0E0D.
  - Expect 4 cycles of arr_load_weight=1 with matching rows, one cycle delayed.
  - Expect seq_done=1 and busy=0 two cycles after the last beat.
- Execution, total_rows=3, rows R0..R2 back-to-back:
  - lane 0 shows R0..R2 at acceptance+1;
  - lane 3 shows them at acceptance+4;
  - busy drops 7 drain cycles after lane-0 feeding ends; done stays set.
- Backpressure/bubbles, total_rows=5 with in_valid toggling 1,0,1,1,0,1,0,1:
  - exactly 5 beats accepted;
  - per-lane valid gaps mirror the bubbles, shifted by lane index;
  - in_ready=0 after the 5th beat.
- Zero rows: start mode 1, total_rows=0.
  - No beats accepted, in_ready stays 0.
  - Done after 1+7+1 cycles.
- Ignored starts:
  - seq_start during EXEC: no effect on the row count.
  - seq_start with mode 3 in IDLE: busy stays 0 and the previous done=1 is retained.
- Reset mid-execution (after 2 of 6 beats): all outputs 0 next cycle. A new mode-0 start then runs cleanly.
